// File: rtl/serial_word_deserializer.sv
// Bit-serial to parallel word deserializer with a one-word output holding register.
// A completed word that cannot be handed off is parked in the shift register, which
// stalls serial input until the output slot frees up.
module serial_word_deserializer #(
  parameter int unsigned N_BITS    = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               abort,
  output logic [N_BITS-1:0]  out_word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [COUNT_W-1:0] word_count
);

  localparam int unsigned CntW = $clog2(N_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(N_BITS - 1);

  logic [N_BITS-1:0] sh_q;
  logic [N_BITS-1:0] sh_shifted;
  logic [CntW-1:0]   cnt_q;
  logic              parked_q;

  logic accept;
  logic last_bit;
  logic slot_free;
  logic load_new;
  logic load_parked;
  logic load;

  // Handshake decode and the shift register value after taking bit_in.
  always_comb begin
    slot_free   = !word_valid || word_ready;
    accept      = bit_valid && !parked_q && !abort;
    last_bit    = accept && (cnt_q == CntLast);
    load_new    = last_bit && slot_free;
    // A parked word never moves on an abort cycle; abort discards it instead.
    load_parked = parked_q && slot_free && !abort;
    load        = load_new || load_parked;
    if (MSB_FIRST) begin
      sh_shifted = {sh_q[N_BITS-2:0], bit_in};
    end else begin
      sh_shifted = {bit_in, sh_q[N_BITS-1:1]};
    end
  end

  // Ready depends only on registered state, so no path from word_ready.
  assign bit_ready = !parked_q;

  // Shift register, bit counter, parked flag and the output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      parked_q   <= 1'b0;
      out_word   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else begin
      if (accept) begin
        sh_q <= sh_shifted;
      end

      if (abort) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= last_bit ? '0 : cnt_q + CntW'(1);
      end

      if (abort) begin
        parked_q <= 1'b0;
      end else if (last_bit && !slot_free) begin
        parked_q <= 1'b1;
      end else if (load_parked) begin
        parked_q <= 1'b0;
      end

      if (load) begin
        out_word   <= load_new ? sh_shifted : sh_q;
        word_valid <= 1'b1;
        if (!(&word_count)) begin
          word_count <= word_count + COUNT_W'(1);
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Collects a bit-serial stream into N_BITS-wide parallel words.
- Acts as the upstream stage that feeds the bit-order reverser.
- Parallel output uses a one-word holding register with a valid/ready handshake.
- Serial input is accepted at full rate; it stalls only when a completed word cannot be handed off.

Parameters:
- N_BITS, 8, word width in bits; must be >= 2.
- MSB_FIRST, 0. When 0, the i-th accepted bit lands in out_word[i]. When 1, it lands in out_word[N_BITS-1-i].
- COUNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is offered this cycle.
- bit_ready  out  1  the block accepts bit_in this cycle.
- abort  in  1  discard the partial or parked word.
- out_word  out  N_BITS  assembled word.
- word_valid  out  1  out_word holds an unconsumed word.
- word_ready  in  1  downstream consumes out_word this cycle.
- word_count  out  COUNT_W  number of words loaded into out_word; saturates at all-ones.

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - shift register, bit count and parked flag cleared.
  - out_word = 0, word_valid = 0, word_count = 0.
  - rst overrides every other input.
- Internal state:
  - shift register sh[N_BITS-1:0].
  - bit count cnt, range 0..N_BITS-1.
  - parked flag: a complete word is waiting in sh.
- bit_ready = !parked. It is registered state only, with no combinational path from word_ready.
- A bit is accepted when bit_valid && bit_ready. It is shifted into sh per MSB_FIRST, and cnt increments.
- slot_free = !word_valid || word_ready.
- Word completion (accepting the bit with cnt == N_BITS-1):
  - If slot_free: the completed word, including this bit, loads into out_word at this edge. word_valid = 1 and cnt = 0.
  - Otherwise: parked = 1 and cnt = 0.
- Latency: last bit accepted at edge k gives word_valid high from edge k.
- Throughput: one bit per cycle sustained while word_ready = 1, with no bubble between words.
- While parked: when slot_free, sh loads into out_word, word_valid stays or becomes 1, and parked clears. bit_ready rises the following cycle.
- Pop without load: word_valid && word_ready with no load that edge gives word_valid = 0. out_word holds its last value.
- Pop and load at the same edge: word_valid stays 1 and out_word takes the new word.
- word_count increments on every load into out_word and saturates at 2^COUNT_W-1.
- abort:
  - Clears cnt and parked; a partial or parked word is lost.
  - A bit offered the same cycle is dropped.
  - out_word, word_valid and word_count are unaffected.
  - A parked word is not loaded on an abort cycle.
- No bit is ever lost or duplicated absent abort or rst.

Test Plan:
1. LSB-first instance, word_ready = 1, bits 0,0,0,0,1,1,1,1 on consecutive cycles -> word_valid for one cycle with out_word = 8'hF0, word_count = 1.
2. MSB_FIRST = 1 instance, same bit sequence -> out_word = 8'h0F.
3. word_ready = 0, stream bytes 0x11 then 0x22 LSB-first, continuous:
   - out_word = 0x11 held, 0x22 parked, bit_ready = 0 after the 16th bit.
   - Raise word_ready for 1 cycle -> out_word = 0x22, word_valid = 1, bit_ready = 1 next cycle, word_count = 2.
4. 5 bits, then abort, then 8 bits of 0x3C -> exactly one word, 0x3C. A bit offered together with abort is ignored.
5. 3 bits, then rst for one cycle, then 8 bits of 0x5A -> all outputs 0 after reset, then a single word 0x5A.
6. COUNT_W = 4, 17 words streamed with word_ready = 1 -> word_count = 15, stable.
